// File: rtl/pool_kxk_stream.sv
// Streaming non-overlapping POOLxPOOL pooling over a raster-scanned signed feature map.
// Optional average mode is compiled in by defining POOL_AVG_EN (adds the pool_mode input).
module pool_kxk_stream #(
    parameter int DW    = 8,
    parameter int IMG_W = 6,
    parameter int IMG_H = 6,
    parameter int POOL  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    input  logic                 in_sof,
    input  logic signed [DW-1:0] in_data,
`ifdef POOL_AVG_EN
    input  logic                 pool_mode,
`endif
    output logic                 out_vld,
    output logic signed [DW-1:0] out_data,
    output logic [($clog2(IMG_H/POOL) > 0 ? $clog2(IMG_H/POOL) : 1)-1:0] out_row,
    output logic [($clog2(IMG_W/POOL) > 0 ? $clog2(IMG_W/POOL) : 1)-1:0] out_col,
    output logic                 frame_done
);

    // Handshake: in_vld qualifies in_sof/in_data each cycle and there is no ready, so every
    // valid pixel is consumed; out_vld is a one-cycle pulse the consumer must take as it comes.

    localparam int OUT_W  = IMG_W / POOL;
    localparam int OUT_H  = IMG_H / POOL;
    localparam int CROP_W = OUT_W * POOL;
    localparam int CROP_H = OUT_H * POOL;
    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);
    localparam int OCW    = ($clog2(OUT_W) > 0) ? $clog2(OUT_W) : 1;
    localparam int ORW    = ($clog2(OUT_H) > 0) ? $clog2(OUT_H) : 1;
`ifdef POOL_AVG_EN
    localparam int SH     = 2 * $clog2(POOL);
    localparam int BW     = DW + SH;

    if ((1 << $clog2(POOL)) != POOL) begin : g_pool_pow2
        $error("pool_kxk_stream: POOL must be a power of two when average mode is built in");
    end
`else
    localparam int BW     = DW;
`endif

    logic [CW-1:0]         col, nxt_col, eff_col;
    logic [RW-1:0]         row, nxt_row, eff_row;
    logic [31:0]           col_w, row_w;
    logic signed [BW-1:0]  pbuf [OUT_W];
    logic signed [BW-1:0]  in_ext, cur, merged, new_val;
    logic signed [DW-1:0]  res;
    logic [OCW-1:0]        idx;
    logic [ORW-1:0]        orow;
    logic                  in_win, win_open, win_close, frame_last;
`ifdef POOL_AVG_EN
    logic signed [BW-1:0]  avg_sh;
`endif

    // in_sof pins the pixel to (0,0); reopening every window on the way drops stale partials.
    always_comb begin
        eff_col    = in_sof ? '0 : col;
        eff_row    = in_sof ? '0 : row;
        col_w      = 32'(eff_col);
        row_w      = 32'(eff_row);
        in_win     = (col_w < CROP_W) && (row_w < CROP_H);
        win_open   = (col_w % POOL == 0) && (row_w % POOL == 0);
        win_close  = (col_w % POOL == POOL - 1) && (row_w % POOL == POOL - 1);
        idx        = OCW'(col_w / POOL);
        orow       = ORW'(row_w / POOL);
        frame_last = (row_w / POOL == OUT_H - 1) && (col_w / POOL == OUT_W - 1);

        in_ext  = BW'(in_data);
        cur     = pbuf[idx];
        merged  = (in_ext > cur) ? in_ext : cur;
`ifdef POOL_AVG_EN
        if (pool_mode) merged = cur + in_ext;
`endif
        new_val = win_open ? in_ext : merged;

        res = merged[DW-1:0];
`ifdef POOL_AVG_EN
        avg_sh = merged >>> SH;
        if (pool_mode) res = avg_sh[DW-1:0];
`endif

        if (col_w == IMG_W - 1) begin
            nxt_col = '0;
            nxt_row = (row_w == IMG_H - 1) ? '0 : RW'(row_w + 1);
        end else begin
            nxt_col = CW'(col_w + 1);
            nxt_row = eff_row;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            for (int i = 0; i < OUT_W; i++) pbuf[i] <= '0;
            out_vld    <= 1'b0;
            out_data   <= '0;
            out_row    <= '0;
            out_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            out_vld    <= 1'b0;
            frame_done <= 1'b0;
            if (in_vld) begin
                col <= nxt_col;
                row <= nxt_row;
                if (in_win) begin
                    pbuf[idx] <= new_val;
                    if (win_close) begin
                        out_vld    <= 1'b1;
                        out_data   <= res;
                        out_row    <= orow;
                        out_col    <= idx;
                        frame_done <= frame_last;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pool_kxk_stream.sv
// Directed bench for pool_kxk_stream: a 6x6/POOL=2 instance and a cropped 7x5/POOL=2 instance.
// Average-mode vectors run only when POOL_AVG_EN is defined.
module tb_pool_kxk_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              a_vld = 0, a_sof = 0;
    logic signed [7:0] a_data = '0;
    logic              a_out_vld, a_fd;
    logic signed [7:0] a_out_data;
    logic [1:0]        a_out_row, a_out_col;
`ifdef POOL_AVG_EN
    logic              a_mode = 0;
`endif

    logic              b_vld = 0, b_sof = 0;
    logic signed [7:0] b_data = '0;
    logic              b_out_vld, b_fd;
    logic signed [7:0] b_out_data;
    logic [0:0]        b_out_row;
    logic [1:0]        b_out_col;

    pool_kxk_stream #(.DW(8), .IMG_W(6), .IMG_H(6), .POOL(2)) dut_a (
        .clk(clk), .rst(rst), .in_vld(a_vld), .in_sof(a_sof), .in_data(a_data),
`ifdef POOL_AVG_EN
        .pool_mode(a_mode),
`endif
        .out_vld(a_out_vld), .out_data(a_out_data), .out_row(a_out_row),
        .out_col(a_out_col), .frame_done(a_fd)
    );

    pool_kxk_stream #(.DW(8), .IMG_W(7), .IMG_H(5), .POOL(2)) dut_b (
        .clk(clk), .rst(rst), .in_vld(b_vld), .in_sof(b_sof), .in_data(b_data),
`ifdef POOL_AVG_EN
        .pool_mode(1'b0),
`endif
        .out_vld(b_out_vld), .out_data(b_out_data), .out_row(b_out_row),
        .out_col(b_out_col), .frame_done(b_fd)
    );

    // Scoreboard entry: {frame_done, row[7:0], col[7:0], data[7:0]}
    localparam int W = 25;
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic exp_push(input int data, input int r, input int c, input bit fd);
        logic [W-1:0] e;
        e = {fd, 8'(r), 8'(c), 8'(data)};
        exp_q.push_back(e);
    endtask

    // Present one input cycle to the selected instance and check its output 1 cycle later.
    task automatic step(input bit sel, input bit v, input bit s, input int d, input bit close);
        logic [W-1:0] e;
        logic         vld, fd;
        logic [7:0]   dat, r8, c8;
        if (!sel) begin a_vld = v; a_sof = s; a_data = 8'(d); end
        else      begin b_vld = v; b_sof = s; b_data = 8'(d); end
        @(posedge clk);
        #1;
        if (!sel) begin vld = a_out_vld; fd = a_fd; dat = a_out_data; r8 = 8'(a_out_row); c8 = 8'(a_out_col); end
        else      begin vld = b_out_vld; fd = b_fd; dat = b_out_data; r8 = 8'(b_out_row); c8 = 8'(b_out_col); end
        check(sel ? "b_out_vld" : "a_out_vld", 32'(vld), 32'(close));
        if (close) begin
            if (exp_q.size() == 0) begin
                check("exp_q_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("out_data",   32'(dat), 32'(e[7:0]));
                check("out_col",    32'(c8),  32'(e[15:8]));
                check("out_row",    32'(r8),  32'(e[23:16]));
                check("frame_done", 32'(fd),  32'(e[24]));
            end
        end else begin
            check(sel ? "b_frame_done" : "a_frame_done", 32'(fd), 32'd0);
        end
    endtask

    function automatic int pix_a(input int kind, input int r, input int c);
        int v;
        v = 0;
        case (kind)
            0: v = r * 6 + c;
            1: begin
                if (r == 0 && c == 0) v = -128;
                if (r == 0 && c == 1) v = -1;
                if (r == 1 && c == 0) v = -5;
                if (r == 1 && c == 1) v = -128;
                if (r < 2 && (c == 2 || c == 3)) v = -128;
            end
            2: v = 50 + r * 6 + c;
            default: begin
                if (r == 0 && c == 0) v = 3;
                if (r == 0 && c == 1) v = 4;
                if (r == 1 && c == 0) v = 5;
                if (r == 1 && c == 1) v = -1;
                if (r < 2 && (c == 2 || c == 3)) v = -1;
                if (r == 1 && c == 3) v = -2;
            end
        endcase
        return v;
    endfunction

    task automatic run_a(input int kind, input bit use_sof, input bit gaps, input int first, input int last);
        int r, c;
        for (int p = first; p <= last; p++) begin
            if (gaps) while ($urandom_range(0, 1) == 1) step(0, 0, 0, 0, 0);
            r = p / 6;
            c = p % 6;
            step(0, 1, use_sof && p == first, pix_a(kind, r, c), (r % 2 == 1) && (c % 2 == 1));
        end
        a_vld = 0;
        a_sof = 0;
    endtask

    task automatic run_b(input bit use_sof);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 7; c++)
                step(1, 1, use_sof && r == 0 && c == 0, r * 7 + c,
                     (r % 2 == 1) && (c % 2 == 1) && r < 4 && c < 6);
        b_vld = 0;
        b_sof = 0;
    endtask

    task automatic push_table_a(input int vals[9]);
        for (int i = 0; i < 9; i++) exp_push(vals[i], i / 3, i % 3, i == 8);
    endtask

    int ramp[9]  = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
    int ramp2[9] = '{57, 59, 61, 69, 71, 73, 81, 83, 85};
    int sgn[9]   = '{-1, -128, 0, 0, 0, 0, 0, 0, 0};
    int avg[9]   = '{2, -2, 0, 0, 0, 0, 0, 0, 0};
    int crop[6]  = '{8, 10, 12, 22, 24, 26};

    initial begin
        // Reset state
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_vld",  32'(a_out_vld),  32'd0);
        check("rst_out_data", 32'(a_out_data), 32'd0);
        check("rst_out_row",  32'(a_out_row),  32'd0);
        check("rst_out_col",  32'(a_out_col),  32'd0);
        check("rst_frame_done", 32'(a_fd),     32'd0);
        check("rst_b_out_vld", 32'(b_out_vld), 32'd0);
        rst = 0;

        // Ramp frame
        push_table_a(ramp);
        run_a(0, 1, 0, 0, 35);
        step(0, 0, 0, 0, 0);
        check("hold_out_data", 32'(a_out_data), 32'h23);
        check("hold_out_col",  32'(a_out_col),  32'd2);

        // Signed windows, starting by counter wrap with no in_sof
        push_table_a(sgn);
        run_a(1, 0, 0, 0, 35);

        // Same ramp frame with random idle gaps
        push_table_a(ramp);
        run_a(0, 1, 1, 0, 35);

        // in_sof at pixel 14: only the first row of windows of the aborted frame completes
        exp_push(7, 0, 0, 0);
        exp_push(9, 0, 1, 0);
        exp_push(11, 0, 2, 0);
        run_a(0, 1, 0, 0, 13);
        push_table_a(ramp2);
        run_a(2, 1, 0, 0, 35);

        // Reset mid-frame: next pixel is (0,0) even without in_sof
        run_a(2, 1, 0, 0, 4);
        rst = 1;
        @(posedge clk);
        #1;
        check("midrst_out_vld", 32'(a_out_vld), 32'd0);
        rst = 0;
        push_table_a(ramp);
        run_a(0, 0, 0, 0, 35);

`ifdef POOL_AVG_EN
        a_mode = 1;
        push_table_a(avg);
        run_a(3, 1, 0, 0, 35);
        a_mode = 0;
`endif

        // Cropped 7x5 instance, two back-to-back frames (second by wrap)
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 6; i++) exp_push(crop[i], i / 3, i % 3, i == 5);
        run_b(1);
        run_b(0);

        step(0, 0, 0, 0, 0);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
